// File: rtl/pcie_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : pcie_tx_drain
// Pops PCIe TX queue words into a 2-entry AXIS buffer with TLP framing and
// truncation. Optional statistics counters: PCIE_TX_STATS_EN.
// Revision: 1.0
// ============================================================================
module pcie_tx_drain #(
  parameter int DATA_W     = 64,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int WIDTH      = DATA_W + KEEP_W + 1,
  parameter int MAX_BEATS  = 64,
  parameter int BUF_AV_MIN = 1
) (
  input  logic              deq_clk,
  input  logic              rst,
  input  logic              q_empty,
  input  logic [WIDTH-1:0]  q_data,
  output logic              q_deq_en,
  output logic [DATA_W-1:0] m_axis_tx_tdata,
  output logic [KEEP_W-1:0] m_axis_tx_tkeep,
  output logic              m_axis_tx_tlast,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready,
  output logic [3:0]        m_axis_tx_tuser,
  input  logic [5:0]        tx_buf_av,
  output logic              err_oversize,
  output logic [31:0]       stat_tlp_cnt,
  output logic [31:0]       stat_drop_cnt
);

  localparam int BC_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IN_PKT = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;

  logic [DATA_W-1:0] data_q [2];
  logic [KEEP_W-1:0] keep_q [2];
  logic [1:0]        last_q;
  logic [1:0]        dsc_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;
  logic              err_q;

  logic              w_q_last;
  logic              pop;
  logic              space;
  logic              av_ok;
  logic              wr;
  logic              wr_last;
  logic              wr_dsc;
  logic              trunc;

  assign w_q_last = q_data[WIDTH-1];
  assign pop      = (cnt_q != 2'd0) & m_axis_tx_tready;
  assign space    = (cnt_q < 2'd2) | pop;
  assign av_ok    = tx_buf_av >= 6'(BUF_AV_MIN);

  // Write-side framing FSM; also produces the queue pop strobe.
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    q_deq_en = 1'b0;
    wr       = 1'b0;
    wr_last  = w_q_last;
    wr_dsc   = 1'b0;
    trunc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!q_empty && space && av_ok) begin
          q_deq_en = 1'b1;
          wr       = 1'b1;
          if (!w_q_last) begin
            bc_d    = BC_W'(1);
            state_d = S_IN_PKT;
          end
        end
      end
      S_IN_PKT: begin
        if (!q_empty && space) begin
          q_deq_en = 1'b1;
          wr       = 1'b1;
          if (w_q_last) begin
            bc_d    = '0;
            state_d = S_IDLE;
          end else if (bc_q == BC_W'(MAX_BEATS - 1)) begin
            // Beat limit reached without last: close the TLP and discard the rest.
            wr_last = 1'b1;
            wr_dsc  = 1'b1;
            trunc   = 1'b1;
            bc_d    = '0;
            state_d = S_DROP;
          end else begin
            bc_d = bc_q + BC_W'(1);
          end
        end
      end
      S_DROP: begin
        if (!q_empty) begin
          q_deq_en = 1'b1;
          if (w_q_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bc_d    = '0;
      end
    endcase
    if (rst) begin
      q_deq_en = 1'b0;
      wr       = 1'b0;
      trunc    = 1'b0;
    end
  end

  always_ff @(posedge deq_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
    end
  end

  always_ff @(posedge deq_clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        keep_q[i] <= '0;
      end
      last_q   <= '0;
      dsc_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= trunc;
      if (wr) begin
        data_q[wr_ptr_q] <= q_data[DATA_W-1:0];
        keep_q[wr_ptr_q] <= q_data[DATA_W +: KEEP_W];
        last_q[wr_ptr_q] <= wr_last;
        dsc_q[wr_ptr_q]  <= wr_dsc;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign m_axis_tx_tvalid = (cnt_q != 2'd0);
  assign m_axis_tx_tdata  = data_q[rd_ptr_q];
  assign m_axis_tx_tkeep  = keep_q[rd_ptr_q];
  assign m_axis_tx_tlast  = m_axis_tx_tvalid & last_q[rd_ptr_q];
  assign m_axis_tx_tuser  = {m_axis_tx_tvalid & dsc_q[rd_ptr_q], 3'b000};
  assign err_oversize     = err_q;

`ifdef PCIE_TX_STATS_EN
  logic [31:0] tlp_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge deq_clk) begin
    if (rst) begin
      tlp_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop && last_q[rd_ptr_q]) begin
        tlp_cnt_q <= tlp_cnt_q + 32'd1;
      end
      if (q_deq_en && (state_q == S_DROP)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign stat_tlp_cnt  = tlp_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_tlp_cnt  = 32'd0;
  assign stat_drop_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcie_tx_drain
// Directed bench for pcie_tx_drain (MAX_BEATS=8); stats checks follow PCIE_TX_STATS_EN.
// Revision: 1.0
// ============================================================================
module tb_pcie_tx_drain;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int QW = DW + KW + 1;
  localparam int MB = 8;

  logic          deq_clk = 1'b0;
  logic          rst = 1'b1;
  logic          q_empty = 1'b1;
  logic [QW-1:0] q_data = '0;
  logic          q_deq_en;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast, tvalid;
  logic          tready = 1'b1;
  logic [3:0]    tuser;
  logic [5:0]    tx_buf_av = 6'd8;
  logic          err_oversize;
  logic [31:0]   stat_tlp_cnt, stat_drop_cnt;

  pcie_tx_drain #(.DATA_W(DW), .MAX_BEATS(MB), .BUF_AV_MIN(1)) dut (
    .deq_clk(deq_clk), .rst(rst), .q_empty(q_empty), .q_data(q_data),
    .q_deq_en(q_deq_en), .m_axis_tx_tdata(tdata), .m_axis_tx_tkeep(tkeep),
    .m_axis_tx_tlast(tlast), .m_axis_tx_tvalid(tvalid), .m_axis_tx_tready(tready),
    .m_axis_tx_tuser(tuser), .tx_buf_av(tx_buf_av), .err_oversize(err_oversize),
    .stat_tlp_cnt(stat_tlp_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 deq_clk = ~deq_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [3:0]    u;
  } beat_t;

  typedef struct {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
    bit            emit;
    logic          exp_last;
    logic          exp_dsc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [QW-1:0] srcq[$];
  beat_t         outq[$];
  int            rd_idx = 0;
  bit            took = 1'b0;
  bit            flush = 1'b0;
  bit            hold = 1'b0;
  beat_t         held, cur;
  int            err_cnt = 0, deq_cnt = 0, viol_deq = 0, viol_stab = 0;

  // Registered-queue model: q_empty reads 1 the cycle after every pop.
  always @(posedge deq_clk) begin
    logic [QW-1:0] tmp;
    #2;
    if (flush) begin
      srcq.delete();
      q_empty = 1'b1;
    end else if (took) begin
      tmp = srcq.pop_front();
      q_empty = 1'b1;
    end else begin
      q_empty = (srcq.size() == 0);
    end
    q_data = (srcq.size() != 0) ? srcq[0] : '0;
  end

  always @(negedge deq_clk) begin
    took = q_deq_en;
    if (!rst) begin
      cur = {tdata, tkeep, tlast, tuser};
      if (tvalid && tready) outq.push_back(cur);
      if (err_oversize) err_cnt++;
      if (q_deq_en) deq_cnt++;
      if (q_deq_en && q_empty) viol_deq++;
      if (hold && !(tvalid && cur == held)) viol_stab++;
      hold = tvalid && !tready;
      held = cur;
    end else begin
      hold = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge deq_clk);
      #1;
    end
  endtask

  task automatic push(input logic last, input logic [KW-1:0] keep, input logic [DW-1:0] data);
    srcq.push_back({last, keep, data});
  endtask

  function automatic beat_t mkb(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                input logic l, input logic dsc);
    beat_t b;
    b = {d, k, l, dsc, 3'b000};
    return b;
  endfunction

  function automatic vec_t mv(input logic last, input logic [KW-1:0] keep, input logic [DW-1:0] data,
                              input bit emit, input logic el, input logic ed);
    vec_t v;
    v.last = last; v.keep = keep; v.data = data;
    v.emit = emit; v.exp_last = el; v.exp_dsc = ed;
    return v;
  endfunction

  task automatic chk_next(input string name, input beat_t exp);
    beat_t act;
    act = (rd_idx < outq.size()) ? outq[rd_idx] : '1;
    rd_idx++;
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (outq.size() < n && c < budget) begin
      cyc(1);
      c++;
    end
    chk("beat_timeout", outq.size(), n);
  endtask

  vec_t vecs[15];

  initial begin
    int d0, d1, nl;

    // 3-beat TLP; 10-beat TLP truncated at 8 (2 dropped); 2-beat TLP after it.
    vecs[0]  = mv(1'b0, 8'hFF, 64'h1001, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mv(1'b0, 8'hFF, 64'h1002, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mv(1'b1, 8'h0F, 64'h1003, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      vecs[3+i] = mv(i == 9, 8'hFF, 64'h3000 + 64'(i), i < 8, i == 7, i == 7);
    vecs[13] = mv(1'b0, 8'hFF, 64'h4001, 1'b1, 1'b0, 1'b0);
    vecs[14] = mv(1'b1, 8'h3F, 64'h4002, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 15; i++) push(vecs[i].last, vecs[i].keep, vecs[i].data);

    cyc(3);
    @(negedge deq_clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_err", err_oversize, 0);
    chk("rst_qempty_low", q_empty, 0);
    chk("rst_no_deq", q_deq_en, 0);
    chk("rst_stats", {stat_tlp_cnt, stat_drop_cnt}, 0);

    cyc(1);
    rst = 1'b0;
    wait_beats(13, 300);
    cyc(10);
    for (int i = 0; i < 15; i++)
      if (vecs[i].emit)
        chk_next($sformatf("tbl_beat%0d", i),
                 mkb(vecs[i].data, vecs[i].keep, vecs[i].exp_last, vecs[i].exp_dsc));
    chk("tbl_no_extra", outq.size(), rd_idx);
    chk("tbl_err_pulses", err_cnt, 1);
    chk("tbl_words_popped", deq_cnt, 15);
`ifdef PCIE_TX_STATS_EN
    chk("stat_tlp", stat_tlp_cnt, 3);
    chk("stat_drop", stat_drop_cnt, 2);
`else
    chk("stat_tlp", stat_tlp_cnt, 0);
    chk("stat_drop", stat_drop_cnt, 0);
`endif

    // 8-beat TLP (exactly MAX_BEATS) with a 10-cycle stall after beat 2.
    for (int i = 0; i < 8; i++) push(i == 7, 8'hFF, 64'h2000 + 64'(i));
    wait_beats(rd_idx + 2, 100);
    tready = 1'b0;
    cyc(4);
    d1 = deq_cnt;
    cyc(6);
    chk("stall_no_deq", deq_cnt - d1, 0);
    chk("stall_no_accept", outq.size(), rd_idx + 2);
    chk("stall_tvalid", tvalid, 1);
    tready = 1'b1;
    wait_beats(rd_idx + 8, 100);
    cyc(4);
    for (int i = 0; i < 8; i++)
      chk_next($sformatf("stall_beat%0d", i), mkb(64'h2000 + 64'(i), 8'hFF, i == 7, 1'b0));
    chk("stall_no_dup", outq.size(), rd_idx);
    chk("max_beats_no_err", err_cnt, 1);

    // Endpoint buffer gating of TLP start.
    tx_buf_av = 6'd0;
    d0 = deq_cnt;
    push(1'b0, 8'hFF, 64'h5001);
    push(1'b1, 8'h01, 64'h5002);
    cyc(20);
    chk("bufav_no_pop", deq_cnt - d0, 0);
    chk("bufav_no_valid", tvalid, 0);
    tx_buf_av = 6'd2;
    @(negedge deq_clk);
    chk("bufav_pop", q_deq_en, 1);
    @(negedge deq_clk);
    chk("bufav_latency", tvalid, 1);
    wait_beats(rd_idx + 2, 50);
    chk_next("bufav_beat0", mkb(64'h5001, 8'hFF, 1'b0, 1'b0));
    chk_next("bufav_beat1", mkb(64'h5002, 8'h01, 1'b1, 1'b0));

    // Reset in the middle of a 5-beat TLP.
    cyc(2);
    for (int i = 0; i < 5; i++) push(i == 4, 8'hFF, 64'h6000 + 64'(i));
    wait_beats(rd_idx + 2, 50);
    rst = 1'b1;
    flush = 1'b1;
    @(negedge deq_clk);
    chk("midrst_no_deq", q_deq_en, 0);
    cyc(1);
    @(negedge deq_clk);
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_tlast", tlast, 0);
    chk("midrst_stats", {stat_tlp_cnt, stat_drop_cnt}, 0);
    nl = 0;
    for (int i = rd_idx; i < outq.size(); i++) if (outq[i].l) nl++;
    chk("midrst_no_tlast", nl, 0);
    rd_idx = outq.size();
    cyc(1);
    rst = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) push(i == 2, 8'hFF, 64'h7000 + 64'(i));
    wait_beats(rd_idx + 3, 50);
    cyc(4);
    for (int i = 0; i < 3; i++)
      chk_next($sformatf("postrst_beat%0d", i), mkb(64'h7000 + 64'(i), 8'hFF, i == 2, 1'b0));
    chk("postrst_no_extra", outq.size(), rd_idx);

    chk("deq_while_empty", viol_deq, 0);
    chk("axis_stability", viol_stab, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
